// File: rtl/blackjack_card_dealer.sv
// blackjack_card_dealer: shared no-replacement shoe with opening deal and reshuffle.
// Optional macro ROUND_ROBIN_EN: alternate grants on contested player/dealer requests.
module blackjack_card_dealer #(
   parameter int          DECK_SIZE = 52,
   parameter int          LOW_WATER = 12,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_round,
   input  logic       player_req,
   input  logic       dealer_req,
   output logic [3:0] card,
   output logic       card_valid,
   output logic       card_to_player,
   output logic       card_to_dealer,
   output logic [6:0] cards_left,
   output logic       round_ready,
   output logic       shuffling
);

   localparam logic [6:0] FULL = 7'(DECK_SIZE);
   localparam logic [6:0] LOW  = 7'(LOW_WATER);

   typedef enum logic [2:0] {
      IDLE, SHUFFLE, DEAL, READY, DRAW, PRESENT
   } state_t;

   state_t      state, state_n;
   state_t      resume, resume_n;
   logic [15:0] lfsr;
   logic [63:0] used;
   logic [6:0]  left_q;
   logic [2:0]  deal_cnt, deal_cnt_n;
   logic        dealing, dealing_n;
   logic        to_p, to_p_n;
   logic [3:0]  rank;
   logic [5:0]  idx;
   logic        hit, take, clear;
   logic        low, grant_p;

   assign idx        = lfsr[5:0];
   assign hit        = (int'(idx) < DECK_SIZE) && !used[idx];
   assign low        = left_q < LOW;
   assign cards_left = left_q;

`ifdef ROUND_ROBIN_EN
   logic last_dealer;
   logic contest;

   assign contest = player_req && dealer_req;
   assign grant_p = player_req && (!dealer_req || last_dealer);

   // Remember the winner of the last contested grant
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         last_dealer <= 1'b1;
      else if (state == READY && !start_round && contest)
         last_dealer <= !grant_p;
   end
`else
   assign grant_p = player_req;
`endif

   // Galois LFSR free-runs every cycle to supply candidate indices
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         lfsr <= LFSR_SEED;
      else
         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Shoe contents, draw latches and deal progress
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         used     <= '0;
         left_q   <= FULL;
         rank     <= '0;
         to_p     <= 1'b0;
         deal_cnt <= '0;
         dealing  <= 1'b0;
         resume   <= IDLE;
      end else begin
         deal_cnt <= deal_cnt_n;
         dealing  <= dealing_n;
         to_p     <= to_p_n;
         resume   <= resume_n;
         if (clear) begin
            used   <= '0;
            left_q <= FULL;
         end else if (take) begin
            used[idx] <= 1'b1;
            left_q    <= left_q - 7'd1;
            rank      <= 4'(idx % 6'd13) + 4'd1;
         end
      end
   end

   // Next-state and output decode
   always_comb begin
      state_n        = state;
      resume_n       = resume;
      deal_cnt_n     = deal_cnt;
      dealing_n      = dealing;
      to_p_n         = to_p;
      take           = 1'b0;
      clear          = 1'b0;
      card           = '0;
      card_valid     = 1'b0;
      card_to_player = 1'b0;
      card_to_dealer = 1'b0;
      round_ready    = 1'b0;
      shuffling      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_round) begin
               deal_cnt_n = '0;
               dealing_n  = 1'b1;
               resume_n   = DEAL;
               state_n    = low ? SHUFFLE : DEAL;
            end
         end
         SHUFFLE: begin
            shuffling = 1'b1;
            clear     = 1'b1;
            state_n   = resume;
         end
         DEAL: begin
            if (deal_cnt == 3'd4) begin
               dealing_n = 1'b0;
               state_n   = READY;
            end else if (left_q == 7'd0) begin
               resume_n = DEAL;
               state_n  = SHUFFLE;
            end else begin
               to_p_n  = !deal_cnt[0];
               state_n = DRAW;
            end
         end
         READY: begin
            round_ready = 1'b1;
            if (start_round) begin
               deal_cnt_n = '0;
               dealing_n  = 1'b1;
               resume_n   = DEAL;
               state_n    = low ? SHUFFLE : DEAL;
            end else if (player_req || dealer_req) begin
               to_p_n   = grant_p;
               resume_n = DRAW;
               state_n  = (left_q == 7'd0) ? SHUFFLE : DRAW;
            end
         end
         DRAW: begin
            if (hit) begin
               take    = 1'b1;
               state_n = PRESENT;
            end
         end
         PRESENT: begin
            card_valid     = 1'b1;
            card           = rank;
            card_to_player = to_p;
            card_to_dealer = !to_p;
            if (dealing) begin
               deal_cnt_n = deal_cnt + 3'd1;
               state_n    = DEAL;
            end else begin
               state_n = READY;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_blackjack_card_dealer.sv
// tb_blackjack_card_dealer: directed checks of the card dealer shoe.
// Build with +define+ROUND_ROBIN_EN to check the alternating-grant variant.
module tb_blackjack_card_dealer;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_round;
   logic       player_req;
   logic       dealer_req;
   logic [3:0] card;
   logic       card_valid;
   logic       card_to_player;
   logic       card_to_dealer;
   logic [6:0] cards_left;
   logic       round_ready;
   logic       shuffling;

   int checks = 0;
   int errors = 0;
   int hist[16];

   int          n, pat, badr, shuf;
   int          a, b, c;
   int          sum_tgt, sum_shuf, sum_lost;
   int          g, cpat;
   logic [15:0] first_ranks, rk;

`ifdef ROUND_ROBIN_EN
   localparam int CONT_EXP = 2;
`else
   localparam int CONT_EXP = 3;
`endif

   always #5 clock = ~clock;

   blackjack_card_dealer dut (
      .clock          (clock),
      .reset          (reset),
      .start_round    (start_round),
      .player_req     (player_req),
      .dealer_req     (dealer_req),
      .card           (card),
      .card_valid     (card_valid),
      .card_to_player (card_to_player),
      .card_to_dealer (card_to_dealer),
      .cards_left     (cards_left),
      .round_ready    (round_ready),
      .shuffling      (shuffling)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      int pulses;
      pulses      = 0;
      player_req  = 1'b0;
      dealer_req  = 1'b0;
      start_round = 1'b0;
      reset       = 1'b1;
      repeat (3) begin
         @(negedge clock);
         if (card_valid) pulses++;
      end
      reset = 1'b0;
      check("rst_valid", card_valid, 0);
      check("rst_card", card, 0);
      check("rst_left", cards_left, 52);
      check("rst_ready", round_ready, 0);
      check("rst_shuf", shuffling, 0);
      player_req = 1'b1;
      repeat (10) begin
         @(negedge clock);
         if (card_valid) pulses++;
      end
      player_req = 1'b0;
      check("idle_ignore", pulses, 0);
   endtask

   task automatic run_deal(output int dn, output int dpat,
                           output int dbad, output int dshuf,
                           output logic [15:0] drk);
      bit done;
      done  = 1'b0;
      dn    = 0;
      dpat  = 0;
      dbad  = 0;
      dshuf = 0;
      drk   = '0;
      start_round = 1'b1;
      for (int i = 0; i < 4000 && !done; i++) begin
         @(negedge clock);
         start_round = 1'b0;
         if (shuffling && dn == 0) dshuf = 1;
         if (card_valid) begin
            dn++;
            dpat = (dpat << 1) | int'(card_to_player);
            if (card_to_player == card_to_dealer) dbad++;
            if (card < 4'd1 || card > 4'd13) dbad++;
            drk = {drk[11:0], card};
            hist[card]++;
         end
         if (round_ready) done = 1'b1;
      end
      start_round = 1'b0;
      check("deal_done", int'(done), 1);
   endtask

   task automatic draw(input bit to_pl, output int tbad,
                       output int tshuf, output int got);
      got   = 0;
      tshuf = 0;
      tbad  = 0;
      player_req = to_pl;
      dealer_req = !to_pl;
      for (int i = 0; i < 5000 && got == 0; i++) begin
         @(negedge clock);
         if (shuffling) tshuf++;
         if (card_valid) begin
            got = 1;
            if (card_to_player != to_pl) tbad = 1;
            if (card_to_dealer == to_pl) tbad = 1;
            if (card < 4'd1 || card > 4'd13) tbad = 1;
            hist[card]++;
            player_req = 1'b0;
            dealer_req = 1'b0;
         end
      end
      player_req = 1'b0;
      dealer_req = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      reset       = 1'b1;
      start_round = 1'b0;
      player_req  = 1'b0;
      dealer_req  = 1'b0;
      do_reset();

      foreach (hist[i]) hist[i] = 0;
      run_deal(n, pat, badr, shuf, first_ranks);
      check("deal_cnt", n, 4);
      check("deal_pat", pat, 10);
      check("deal_bad", badr, 0);
      check("deal_shuf", shuf, 0);
      check("deal_left", cards_left, 48);
      check("deal_ready", round_ready, 1);

      sum_tgt  = 0;
      sum_shuf = 0;
      sum_lost = 0;
      for (int i = 0; i < 48; i++) begin
         draw(i % 2 == 0, a, b, c);
         sum_tgt  += a;
         sum_shuf += b;
         sum_lost += 1 - c;
      end
      check("drain_tgt", sum_tgt, 0);
      check("drain_shuf", sum_shuf, 0);
      check("drain_lost", sum_lost, 0);
      check("drain_left", cards_left, 0);
      for (int r = 1; r <= 13; r++)
         check($sformatf("rank%0d", r), hist[r], 4);

      draw(1'b1, a, b, c);
      check("reshuf_pulse", b, 1);
      check("reshuf_got", c, 1);
      check("reshuf_tgt", a, 0);
      check("reshuf_left", cards_left, 51);

      sum_lost = 0;
      for (int i = 0; i < 40; i++) begin
         draw(i % 2 == 1, a, b, c);
         sum_lost += 1 - c;
      end
      check("lw_lost", sum_lost, 0);
      check("lw_prep", cards_left, 11);
      run_deal(n, pat, badr, shuf, rk);
      check("lw_shuf", shuf, 1);
      check("lw_cnt", n, 4);
      check("lw_pat", pat, 10);
      check("lw_left", cards_left, 48);

      g    = 0;
      cpat = 0;
      player_req = 1'b1;
      dealer_req = 1'b1;
      for (int i = 0; i < 5000 && g < 2; i++) begin
         @(negedge clock);
         if (card_valid) begin
            g++;
            cpat = (cpat << 1) | int'(card_to_player);
         end
      end
      player_req = 1'b0;
      dealer_req = 1'b0;
      @(negedge clock);
      check("cont_cnt", g, 2);
      check("cont_pat", cpat, CONT_EXP);
      check("cont_left", cards_left, 46);

      player_req = 1'b1;
      @(negedge clock);
      check("abort_pre", card_valid, 0);
      do_reset();
      run_deal(n, pat, badr, shuf, rk);
      check("lfsr_restart", int'(rk == first_ranks), 1);
      check("restart_left", cards_left, 48);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
